wb_bus_arbiter: RTL and testbench

Shares the single peripheral Wishbone bus (UART/SPI/VGA decode downstream) between NUM_MASTERS requesters, e.g. CPU data port (master 0) and DMA/debug port (master 1). The arbiter is round-robin with a bus lock for the duration of the owner's cyc. A watchdog terminates transfers that receive no ack. It sits between the masters and the existing slave-select/decode logic.

---
 rtl/wb_arb_pkg.sv | 44 ++++
 rtl/wb_bus_arbiter_if.sv | 46 ++++
 rtl/wb_rr_picker.sv | 33 +++
 rtl/wb_bus_arbiter.sv | 118 +++++++++++
 tb/tb_wb_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone peripheral-bus arbiter.
// Holds the FSM state type and the round-robin search used by the picker.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ERR   = 2'd2
  } arb_state_t;

  localparam int MAX_MASTERS = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;

  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

  localparam int SEL_W = sel_width(DEF_DATA_W);

  // First set bit of req at or after ptr, wrapping within n entries.
  // Returns 0 when req is empty, so callers need a separate valid flag.
  function automatic logic [1:0] rr_next_idx(input logic [MAX_MASTERS-1:0] req,
                                             input int unsigned ptr,
                                             input int unsigned n);
    logic        found;
    logic [1:0]  pick;
    int unsigned cand;
    found = 1'b0;
    pick  = 2'd0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      cand = ptr + k;
      if (cand >= n) begin
        cand = cand - n;
      end
      if (k < n && !found && req[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// The arbiter uses the slave modport; the driving environment uses master.
interface wb_bus_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
);
  localparam int SEL_BITS = sel_width(DATA_W);

  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS-1:0][SEL_BITS-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_adr_i;
  logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_dat_i;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_err_o;
  logic [DATA_W-1:0]                    m_dat_o;
  logic [NUM_MASTERS-1:0]               grant_o;

  logic                                 s_cyc_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [SEL_BITS-1:0]                  s_sel_o;
  logic [ADDR_W-1:0]                    s_adr_o;
  logic [DATA_W-1:0]                    s_dat_o;
  logic                                 s_ack_i;
  logic [DATA_W-1:0]                    s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_ack_o, m_err_o, m_dat_o, grant_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, grant_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational round-robin priority encoder: request vector plus pointer
// in, one-hot grant (and its index) out.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [1:0]             pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_next_idx(req_ext, 32'(ptr), N);
    valid          = |req;
    idx            = IDX_W'(pick);
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = valid && (pick == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone peripheral bus between masters,
// with bus lock for the owner's cyc and an ack watchdog.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  wb_bus_arbiter_if.slave  bus
);

  localparam int          IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t             state_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [NUM_MASTERS-1:0] err_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic [IDX_W-1:0]       ptr_reg;
  logic [15:0]            to_cnt_reg;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   owned;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   stalled;
  logic [IDX_W-1:0]       owner_inc;

  wb_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (bus.m_cyc_i),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    owned     = (state_reg == OWNED);
    own_cyc   = owned && bus.m_cyc_i[owner_reg];
    own_stb   = own_cyc && bus.m_stb_i[owner_reg];
    stalled   = own_stb && !bus.s_ack_i;
    owner_inc = (owner_reg == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_reg + IDX_W'(1);
  end

  // Slave side follows the owner only while it holds cyc; everything is
  // zero outside OWNED so idle/error/reset cycles present a quiet bus.
  assign bus.s_cyc_o = own_cyc;
  assign bus.s_stb_o = own_stb;
  assign bus.s_we_o  = own_cyc && bus.m_we_i[owner_reg];
  assign bus.s_sel_o = own_cyc ? bus.m_sel_i[owner_reg] : '0;
  assign bus.s_adr_o = own_cyc ? bus.m_adr_i[owner_reg] : '0;
  assign bus.s_dat_o = own_cyc ? bus.m_dat_i[owner_reg] : '0;

  assign bus.m_ack_o = (owned && bus.s_ack_i) ? grant_reg : '0;
  assign bus.m_dat_o = owned ? bus.s_dat_i : '0;
  assign bus.m_err_o = err_reg;
  assign bus.grant_o = grant_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      err_reg    <= '0;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      to_cnt_reg <= '0;
    end else begin
      err_reg <= '0;
      case (state_reg)
        IDLE: begin
          to_cnt_reg <= '0;
          if (pick_valid) begin
            state_reg <= OWNED;
            grant_reg <= pick_grant;
            owner_reg <= pick_idx;
          end
        end
        OWNED: begin
          if (!bus.m_cyc_i[owner_reg]) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            ptr_reg    <= owner_inc;
            to_cnt_reg <= '0;
          end else if (stalled && to_cnt_reg == TO_LIMIT) begin
            // An ack on this edge would clear stalled, so ack beats the limit.
            state_reg  <= ERR;
            err_reg    <= grant_reg;
            to_cnt_reg <= '0;
          end else if (stalled) begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
          end else begin
            to_cnt_reg <= '0;
          end
        end
        ERR: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          ptr_reg   <= owner_inc;
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_wb_bus_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  // behavioural model: who owns the bus, whether it is in its error cycle
  int   md_owner = -1;
  bit   md_err = 1'b0;
  int   md_ptr = 0;
  int   md_stall = 0;

  wb_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus();

  wb_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  // Model update: decides ownership from the request rules with plain ints.
  always @(posedge clk) begin
    if (!rst_n) begin
      md_owner = -1;
      md_err   = 1'b0;
      md_ptr   = 0;
      md_stall = 0;
    end else if (md_owner < 0) begin
      for (int k = 0; k < NM; k++) begin
        int cand;
        cand = (md_ptr + k) % NM;
        if (md_owner < 0 && bus.m_cyc_i[cand]) begin
          md_owner = cand;
          md_stall = 0;
        end
      end
    end else if (md_err) begin
      md_ptr   = (md_owner + 1) % NM;
      md_owner = -1;
      md_err   = 1'b0;
    end else if (!bus.m_cyc_i[md_owner]) begin
      md_ptr   = (md_owner + 1) % NM;
      md_owner = -1;
      md_stall = 0;
    end else if (bus.m_stb_i[md_owner] && !bus.s_ack_i) begin
      md_stall++;
      if (md_stall == TO) begin
        md_err   = 1'b1;
        md_stall = 0;
      end
    end else begin
      md_stall = 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NM-1:0] e_grant, e_ack, e_err;
      logic [DW-1:0] e_mdat, e_sdat;
      logic          e_cyc, e_stb, e_we;
      logic [SEL_W-1:0] e_sel;
      logic [AW-1:0] e_adr;
      e_grant = '0; e_ack = '0; e_err = '0; e_mdat = '0; e_sdat = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0;
      if (md_owner >= 0) begin
        e_grant = NM'(1) << md_owner;
        if (md_err) begin
          e_err = e_grant;
        end else begin
          if (bus.m_cyc_i[md_owner]) begin
            e_cyc  = 1'b1;
            e_stb  = bus.m_stb_i[md_owner];
            e_we   = bus.m_we_i[md_owner];
            e_sel  = bus.m_sel_i[md_owner];
            e_adr  = bus.m_adr_i[md_owner];
            e_sdat = bus.m_dat_i[md_owner];
          end
          if (bus.s_ack_i) e_ack = e_grant;
          e_mdat = bus.s_dat_i;
        end
      end
      chk("m_grant", 64'(bus.grant_o), 64'(e_grant));
      chk("m_ack", 64'(bus.m_ack_o), 64'(e_ack));
      chk("m_err", 64'(bus.m_err_o), 64'(e_err));
      chk("m_mdat", 64'(bus.m_dat_o), 64'(e_mdat));
      chk("m_scyc", 64'(bus.s_cyc_o), 64'(e_cyc));
      chk("m_sstb", 64'(bus.s_stb_o), 64'(e_stb));
      chk("m_swe", 64'(bus.s_we_o), 64'(e_we));
      chk("m_ssel", 64'(bus.s_sel_o), 64'(e_sel));
      chk("m_sadr", 64'(bus.s_adr_o), 64'(e_adr));
      chk("m_sdat", 64'(bus.s_dat_o), 64'(e_sdat));
      chk("inv_onehot", 64'($countones(bus.grant_o) > 1), 64'(0));
      chk("inv_ack_err", 64'(bus.m_ack_o & bus.m_err_o), 64'(0));
    end
  end

  logic [DW-1:0] lock_vals [3];
  int ack_pct;

  initial begin
    lock_vals[0] = 32'h4f3f2f1f;
    lock_vals[1] = 32'h11111111;
    lock_vals[2] = 32'h22222222;

    // reset state and single master write
    do_reset();
    mid();
    chk("rst_grant", 64'(bus.grant_o), 64'h0);
    chk("rst_scyc", 64'(bus.s_cyc_o), 64'h0);
    chk("rst_err", 64'(bus.m_err_o), 64'h0);
    step();
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b01;
    bus.m_sel_i[0] = 4'b0110; bus.m_adr_i[0] = 16'h0501; bus.m_dat_i[0] = 32'h0059ea00;
    mid();
    chk("wr_pre_grant", 64'(bus.grant_o), 64'h0);
    step(); mid();
    chk("wr_grant", 64'(bus.grant_o), 64'h1);
    chk("wr_scyc", 64'(bus.s_cyc_o), 64'h1);
    chk("wr_swe", 64'(bus.s_we_o), 64'h1);
    chk("wr_sadr", 64'(bus.s_adr_o), 64'h0501);
    chk("wr_ssel", 64'(bus.s_sel_o), 64'h6);
    chk("wr_sdat", 64'(bus.s_dat_o), 64'h0059ea00);
    chk("wr_noack", 64'(bus.m_ack_o), 64'h0);
    step(); bus.s_ack_i = 1'b1; mid();
    chk("wr_ack", 64'(bus.m_ack_o), 64'h1);
    chk("wr_noerr", 64'(bus.m_err_o), 64'h0);
    step(); idle_inputs(); mid();
    chk("wr_ack_once", 64'(bus.m_ack_o), 64'h0);
    step(); mid();
    chk("wr_release", 64'(bus.grant_o), 64'h0);

    // contention and fairness
    do_reset();
    bus.m_cyc_i = 2'b11; mid();
    step(); mid();
    chk("ct_first", 64'(bus.grant_o), 64'h1);
    step(); bus.m_cyc_i = 2'b10; mid();
    chk("ct_hold", 64'(bus.grant_o), 64'h1);
    step(); mid();
    chk("ct_dead", 64'(bus.grant_o), 64'h0);
    step(); mid();
    chk("ct_second", 64'(bus.grant_o), 64'h2);
    step(); bus.m_cyc_i = 2'b00; mid();
    step(); bus.m_cyc_i = 2'b11; mid();
    chk("ct_dead2", 64'(bus.grant_o), 64'h0);
    step(); mid();
    chk("ct_fair", 64'(bus.grant_o), 64'h1);
    step(); idle_inputs(); step();

    // lock across three reads while master1 waits
    do_reset();
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b01; mid();
    step();
    for (int b = 0; b < 3; b++) begin
      bus.s_ack_i = 1'b1; bus.s_dat_i = lock_vals[b]; mid();
      chk("lk_grant", 64'(bus.grant_o), 64'h1);
      chk("lk_ack", 64'(bus.m_ack_o), 64'h1);
      chk("lk_dat", 64'(bus.m_dat_o), 64'(lock_vals[b]));
      step();
    end
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b00; mid();
    chk("lk_rel", 64'(bus.grant_o), 64'h1);
    step(); mid();
    chk("lk_dead", 64'(bus.grant_o), 64'h0);
    step(); mid();
    chk("lk_m1", 64'(bus.grant_o), 64'h2);
    step(); idle_inputs(); step();

    // watchdog timeout
    do_reset();
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; mid();
    step();
    for (int c = 1; c <= TO; c++) begin
      mid();
      chk("to_stall_err", 64'(bus.m_err_o), 64'h0);
      chk("to_stall_stb", 64'(bus.s_stb_o), 64'h1);
      step();
    end
    bus.m_cyc_i = 2'b11; mid();
    chk("to_err", 64'(bus.m_err_o), 64'h1);
    chk("to_scyc", 64'(bus.s_cyc_o), 64'h0);
    chk("to_ack", 64'(bus.m_ack_o), 64'h0);
    step(); mid();
    chk("to_idle", 64'(bus.grant_o), 64'h0);
    chk("to_err_once", 64'(bus.m_err_o), 64'h0);
    step(); mid();
    chk("to_ptr", 64'(bus.grant_o), 64'h2);
    step(); idle_inputs(); step();

    // ack on the limiting cycle wins
    do_reset();
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; mid();
    step();
    for (int c = 1; c < TO; c++) step();
    bus.s_ack_i = 1'b1; mid();
    chk("lim_ack", 64'(bus.m_ack_o), 64'h1);
    chk("lim_err", 64'(bus.m_err_o), 64'h0);
    step(); bus.s_ack_i = 1'b0; bus.m_stb_i = 2'b00; mid();
    chk("lim_noerr", 64'(bus.m_err_o), 64'h0);
    chk("lim_grant", 64'(bus.grant_o), 64'h1);
    step(); idle_inputs(); step();

    // reset mid-transfer restores pointer
    do_reset();
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.s_ack_i = 1'b1; mid();
    step(); mid();
    step(); bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    step(); bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; mid();
    step(); mid();
    chk("rm_regrant", 64'(bus.grant_o), 64'h1);
    step(); step();
    rst_n = 1'b0; mid();
    step(); bus.s_ack_i = 1'b1; mid();
    chk("rm_grant", 64'(bus.grant_o), 64'h0);
    chk("rm_scyc", 64'(bus.s_cyc_o), 64'h0);
    chk("rm_ack", 64'(bus.m_ack_o), 64'h0);
    chk("rm_err", 64'(bus.m_err_o), 64'h0);
    bus.m_cyc_i = 2'b11; bus.s_ack_i = 1'b0; rst_n = 1'b1;
    step(); mid();
    chk("rm_ptr", 64'(bus.grant_o), 64'h1);
    step(); idle_inputs(); step();

    // randomized traffic, model-checked every cycle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ack_pct = (n < 1500) ? 50 : 8;
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 7) == 0) bus.m_cyc_i[i] = ~bus.m_cyc_i[i];
        bus.m_stb_i[i] = bus.m_cyc_i[i] & ($urandom_range(0, 3) != 0);
        bus.m_we_i[i]  = 1'($urandom);
        bus.m_sel_i[i] = SEL_W'($urandom);
        bus.m_adr_i[i] = AW'($urandom);
        bus.m_dat_i[i] = $urandom;
      end
      bus.s_ack_i = ($urandom_range(0, 99) < ack_pct);
      bus.s_dat_i = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
